// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder controller. One shared 1-bit full-adder cell (two hadd1
//   half-adders and an OR for the carry) is stepped over WIDTH clock cycles to
//   add two WIDTH-bit operands, LSB first. A start/done handshake lets a host
//   issue additions without a WIDTH-bit ripple adder.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request a new addition (accepted only in IDLE/DONE)
//   a      in   WIDTH  operand A, captured on an accepted start
//   b      in   WIDTH  operand B, captured on an accepted start
//   busy   out  1      high while the serial addition is running
//   done   out  1      one-cycle pulse: sum/cout hold the new result
//   sum    out  WIDTH  last completed result
//   cout   out  1      carry out of the MSB, held together with sum
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// hadd1
//   1-bit half adder.
//   i_a, i_b  in   addend bits
//   o_s       out  sum bit
//   o_c       out  carry bit
// -----------------------------------------------------------------------------
module hadd1 (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_ps;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_ha0_s;
  logic             w_ha0_c;
  logic             w_ha1_s;
  logic             w_ha1_c;
  logic             w_carry;
  logic [WIDTH-1:0] w_ps_next;

  // Shared full-adder cell: bit 0 of each operand shift register plus the
  // running carry.
  hadd1 u_ha0 (
    .i_a (r_ra[0]),
    .i_b (r_rb[0]),
    .o_s (w_ha0_s),
    .o_c (w_ha0_c)
  );

  hadd1 u_ha1 (
    .i_a (w_ha0_s),
    .i_b (r_c),
    .o_s (w_ha1_s),
    .o_c (w_ha1_c)
  );

  assign w_carry = w_ha0_c | w_ha1_c;

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at index 0.
  assign w_ps_next = {w_ha1_s, r_ps[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_ra    <= a;
            r_rb    <= b;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        S_RUN: begin
          r_ra <= {1'b0, r_ra[WIDTH-1:1]};
          r_rb <= {1'b0, r_rb[WIDTH-1:1]};
          r_c  <= w_carry;
          r_ps <= w_ps_next;
          // sum/cout are written only here so the host never sees a
          // partially assembled result.
          if (r_cnt == CNT_LAST) begin
            r_sum   <= w_ps_next;
            r_cout  <= w_carry;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Directed self-checking bench for serial_add_ctrl with WIDTH=8. Inputs are
//   driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_checks;
  int n_fail;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one addition from a falling edge and wait (bounded) for done.
  // lat counts falling edges from the start edge until done is seen.
  task automatic run_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         output int lat);
    a     = ta;
    b     = tb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH:0]   exp9;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;

    // 1: reset
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'h00);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 2: 0x0F + 0x01, cycle-by-cycle handshake
    a     = 8'h0F;
    b     = 8'h01;
    start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("t2_busy_c%0d", cyc), 32'(busy), 32'd1);
      check($sformatf("t2_done_c%0d", cyc), 32'(done), 32'd0);
      check($sformatf("t2_hold_c%0d", cyc), 32'(sum),  32'h00);
    end
    @(negedge clk);
    check("t2_done",   32'(done), 32'd1);
    check("t2_busy9",  32'(busy), 32'd0);
    check("t2_sum",    32'(sum),  32'h10);
    check("t2_cout",   32'(cout), 32'd0);
    @(negedge clk);
    check("t2_done_off", 32'(done), 32'd0);
    check("t2_sum_hold", 32'(sum),  32'h10);

    // 3: carry out
    run_add(8'hFF, 8'h01, lat);
    check("t3a_lat",  32'(lat),  32'd9);
    check("t3a_sum",  32'(sum),  32'h00);
    check("t3a_cout", 32'(cout), 32'd1);
    @(negedge clk);
    run_add(8'hFF, 8'hFF, lat);
    check("t3b_lat",  32'(lat),  32'd9);
    check("t3b_sum",  32'(sum),  32'hFE);
    check("t3b_cout", 32'(cout), 32'd1);
    @(negedge clk);

    // 4: start and operands disturbed mid-run
    a     = 8'h12;
    b     = 8'h34;
    start = 1'b1;
    ndone = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("t4_done_cyc", 32'(cyc),  32'd9);
        check("t4_sum",      32'(sum),  32'h46);
        check("t4_cout",     32'(cout), 32'd0);
      end else if (cyc < 9) begin
        check($sformatf("t4_hold_c%0d", cyc), 32'(sum), 32'hFE);
      end
      start = (cyc == 3);
      if (cyc == 3) begin
        a = 8'hFF;
        b = 8'hFF;
      end
    end
    check("t4_ndone", 32'(ndone), 32'd1);

    // 5: back-to-back start held in the DONE cycle
    run_add(8'h10, 8'h20, lat);
    check("t5a_lat", 32'(lat), 32'd9);
    check("t5a_sum", 32'(sum), 32'h30);
    a     = 8'h03;
    b     = 8'h04;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_busy_next", 32'(busy), 32'd1);
    check("t5_done_next", 32'(done), 32'd0);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t5b_lat",  32'(lat),  32'd9);
    check("t5b_sum",  32'(sum),  32'h07);
    check("t5b_cout", 32'(cout), 32'd0);
    @(negedge clk);

    // 6: reset in the middle of a run
    a     = 8'h55;
    b     = 8'h22;
    start = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_sum",  32'(sum),  32'h00);
    check("t6_cout", 32'(cout), 32'd0);
    ndone = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("t6_no_activity", 32'(ndone), 32'd0);

    // rst and start on the same edge: reset wins
    a     = 8'h01;
    b     = 8'h01;
    start = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("t6_rst_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t6_rst_start_busy2", 32'(busy), 32'd0);
    check("t6_rst_start_done",  32'(done), 32'd0);

    // Corner and random operands
    for (int i = 0; i < 24; i++) begin
      if (i == 0) begin
        ra = 8'h00; rb = 8'h00;
      end else if (i == 1) begin
        ra = 8'h80; rb = 8'h80;
      end else if (i == 2) begin
        ra = 8'hAA; rb = 8'h55;
      end else begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
      end
      exp9 = {1'b0, ra} + {1'b0, rb};
      run_add(ra, rb, lat);
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd9);
      check($sformatf("rnd%0d_%0h+%0h", i, ra, rb), 32'({cout, sum}), 32'(exp9));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
